// File: rtl/instr_mem_responder_if.sv
// Instruction fetch bus between the fetch stage (master) and the
// instruction memory responder (slave).
interface instr_mem_responder_if;
  logic        instr_req_i;
  logic        instr_gnt_o;
  logic [31:0] instr_addr_i;
  logic [31:0] instr_rdata_o;
  logic        instr_rvalid_o;
  logic        instr_err_o;

  modport slave (
    input  instr_req_i,
    input  instr_addr_i,
    output instr_gnt_o,
    output instr_rdata_o,
    output instr_rvalid_o,
    output instr_err_o
  );

  modport master (
    output instr_req_i,
    output instr_addr_i,
    input  instr_gnt_o,
    input  instr_rdata_o,
    input  instr_rvalid_o,
    input  instr_err_o
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: grants fetch requests, returns one word per
// grant after a fixed LATENCY through a shift-register delay line, flags
// out-of-range fetches with err, and accepts program loads on a side port.
module instr_mem_responder #(
  parameter int          DEPTH_WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_mem_responder_if.slave  bus,
  input  logic                  wait_i,
  input  logic                  load_we_i,
  input  logic [31:0]           load_addr_i,
  input  logic [31:0]           load_wdata_i
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  // 33-bit bounds so the top of a memory ending at 2^32 does not wrap to 0.
  localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI_ADDR = LO_ADDR + 33'(64'(DEPTH_WORDS) * 64'd4);
  // Up to 4 stages can be valid, so 3 bits hold the in-flight count.
  localparam int          CNT_W = 3;

  logic [31:0]        mem [DEPTH_WORDS];

  logic [LATENCY-1:0] stg_vld;
  logic [LATENCY-1:0] stg_err;
  logic [31:0]        stg_dat [LATENCY];

  logic               fetch_in_range;
  logic [31:0]        fetch_off;
  logic [IDX_W-1:0]   fetch_idx;
  logic               load_in_range;
  logic [31:0]        load_off;
  logic [IDX_W-1:0]   load_idx;

  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   outstanding;
  logic               gnt;

  assign fetch_in_range = ({1'b0, bus.instr_addr_i} >= LO_ADDR) &&
                          ({1'b0, bus.instr_addr_i} <  HI_ADDR);
  assign fetch_off      = bus.instr_addr_i - BASE_ADDR;
  assign fetch_idx      = fetch_off[IDX_W+1:2];

  assign load_in_range  = ({1'b0, load_addr_i} >= LO_ADDR) &&
                          ({1'b0, load_addr_i} <  HI_ADDR);
  assign load_off       = load_addr_i - BASE_ADDR;
  assign load_idx       = load_off[IDX_W+1:2];

  // Byte-lane bits and the bits above the index are covered by the range
  // compare; they are not needed once the offset is known to be in range.
  logic unused_off_bits;
  assign unused_off_bits = ^{fetch_off[31:IDX_W+2], fetch_off[1:0],
                             load_off[31:IDX_W+2],  load_off[1:0]};

  // Count valid delay-line entries; the one in the last stage retires this cycle.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + CNT_W'(stg_vld[i]);
    end
  end

  assign outstanding     = inflight - CNT_W'(stg_vld[LATENCY-1]);
  assign gnt             = bus.instr_req_i & ~wait_i & ~rst &
                           (outstanding < CNT_W'(MAX_OUTSTANDING));
  assign bus.instr_gnt_o = gnt;

  // Delay line: stage 0 captures the memory word read in the grant cycle; the
  // data/err of empty stages is held at zero so the outputs need no gating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld <= '0;
      stg_err <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stg_dat[i] <= '0;
      end
    end else begin
      stg_vld[0] <= gnt;
      stg_err[0] <= gnt & ~fetch_in_range;
      stg_dat[0] <= (gnt && fetch_in_range) ? mem[fetch_idx] : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        stg_vld[i] <= stg_vld[i-1];
        stg_err[i] <= stg_err[i-1];
        stg_dat[i] <= stg_dat[i-1];
      end
    end
  end

  // Program load; a same-edge fetch of this word has already sampled the old value.
  always_ff @(posedge clk) begin
    if (load_we_i && load_in_range) begin
      mem[load_idx] <= load_wdata_i;
    end
  end

  assign bus.instr_rvalid_o = stg_vld[LATENCY-1];
  assign bus.instr_err_o    = stg_err[LATENCY-1];
  assign bus.instr_rdata_o  = stg_dat[LATENCY-1];

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench: a LATENCY=1 and a LATENCY=3 responder share clock, reset,
// wait and load port; each has its own fetch bus.
module tb_instr_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wait_sig = 1'b0;
  logic        load_we = 1'b0;
  logic [31:0] load_addr = 32'h0;
  logic [31:0] load_wdata = 32'h0;

  int total  = 0;
  int passed = 0;

  instr_mem_responder_if bus1 ();
  instr_mem_responder_if bus3 ();

  instr_mem_responder #(
    .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1), .MAX_OUTSTANDING(2)
  ) u_l1 (
    .clk(clk), .rst(rst), .bus(bus1), .wait_i(wait_sig),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata)
  );

  instr_mem_responder #(
    .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3), .MAX_OUTSTANDING(2)
  ) u_l3 (
    .clk(clk), .rst(rst), .bus(bus3), .wait_i(wait_sig),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    load_we    = 1'b1;
    load_addr  = a;
    load_wdata = d;
  endtask

  logic [31:0] prog [4];
  logic [5:0]  gnt_pat;
  logic [8:0]  rv_pat;

  initial begin
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0010_0093;
    prog[2] = 32'h0020_8113;
    prog[3] = 32'h0031_0193;
    gnt_pat = 6'b011011;
    rv_pat  = 9'b011011000;

    bus1.instr_req_i  = 1'b1;
    bus1.instr_addr_i = 32'h0;
    bus3.instr_req_i  = 1'b1;
    bus3.instr_addr_i = 32'h0;

    // Reset state: no grant while rst is high, outputs cleared.
    @(negedge clk); #1;
    chk("rst_gnt1",   32'(bus1.instr_gnt_o),    32'h0);
    chk("rst_gnt3",   32'(bus3.instr_gnt_o),    32'h0);
    chk("rst_rvalid", 32'(bus1.instr_rvalid_o), 32'h0);
    chk("rst_err",    32'(bus1.instr_err_o),    32'h0);
    chk("rst_rdata",  bus1.instr_rdata_o,       32'h0);

    bus1.instr_req_i = 1'b0;
    bus3.instr_req_i = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) load_word(32'(4 * i), prog[i]);

    // Four back-to-back fetches on the LATENCY=1 responder.
    @(negedge clk);
    load_we = 1'b0;
    bus1.instr_req_i  = 1'b1;
    bus1.instr_addr_i = 32'h0;
    #1 chk("b2b_gnt0", 32'(bus1.instr_gnt_o), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i < 4) bus1.instr_addr_i = 32'(4 * i);
      else       bus1.instr_req_i  = 1'b0;
      #1;
      chk("b2b_rvalid", 32'(bus1.instr_rvalid_o), 32'h1);
      chk("b2b_rdata",  bus1.instr_rdata_o,       prog[i-1]);
      chk("b2b_err",    32'(bus1.instr_err_o),    32'h0);
      if (i < 4) chk("b2b_gnt", 32'(bus1.instr_gnt_o), 32'h1);
    end
    @(negedge clk); #1;
    chk("b2b_idle_rvalid", 32'(bus1.instr_rvalid_o), 32'h0);
    chk("b2b_idle_rdata",  bus1.instr_rdata_o,       32'h0);

    // Out-of-range fetch, then in-range, then the very top of the address space.
    @(negedge clk);
    bus1.instr_req_i  = 1'b1;
    bus1.instr_addr_i = 32'h0000_1000;
    #1 chk("oor_gnt", 32'(bus1.instr_gnt_o), 32'h1);
    @(negedge clk);
    bus1.instr_addr_i = 32'h0000_0004;
    #1;
    chk("oor_rvalid", 32'(bus1.instr_rvalid_o), 32'h1);
    chk("oor_err",    32'(bus1.instr_err_o),    32'h1);
    chk("oor_rdata",  bus1.instr_rdata_o,       32'h0);
    @(negedge clk);
    bus1.instr_addr_i = 32'hFFFF_FFFC;
    #1;
    chk("after_oor_err",   32'(bus1.instr_err_o), 32'h0);
    chk("after_oor_rdata", bus1.instr_rdata_o,    32'h0010_0093);
    chk("top_gnt",         32'(bus1.instr_gnt_o), 32'h1);
    @(negedge clk);
    bus1.instr_req_i = 1'b0;
    #1;
    chk("top_rvalid", 32'(bus1.instr_rvalid_o), 32'h1);
    chk("top_err",    32'(bus1.instr_err_o),    32'h1);
    chk("top_rdata",  bus1.instr_rdata_o,       32'h0);

    // Wait-state injection: one grant, then five blocked cycles.
    @(negedge clk);
    bus1.instr_req_i  = 1'b1;
    bus1.instr_addr_i = 32'h0;
    #1 chk("wait_pre_gnt", 32'(bus1.instr_gnt_o), 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      wait_sig = 1'b1;
      #1;
      chk("wait_gnt",    32'(bus1.instr_gnt_o),    32'h0);
      chk("wait_rvalid", 32'(bus1.instr_rvalid_o), (k == 0) ? 32'h1 : 32'h0);
      if (k == 0) chk("wait_rdata", bus1.instr_rdata_o, 32'h0000_0013);
    end
    @(negedge clk);
    wait_sig = 1'b0;
    #1 chk("wait_resume_gnt", 32'(bus1.instr_gnt_o), 32'h1);
    @(negedge clk);
    bus1.instr_req_i = 1'b0;
    #1 chk("wait_resume_rdata", bus1.instr_rdata_o, 32'h0000_0013);

    // Fetch and load hit word 2 in the same cycle.
    @(negedge clk);
    bus1.instr_req_i  = 1'b1;
    bus1.instr_addr_i = 32'h8;
    load_we    = 1'b1;
    load_addr  = 32'h8;
    load_wdata = 32'hDEAD_BEEF;
    #1 chk("coll_gnt", 32'(bus1.instr_gnt_o), 32'h1);
    @(negedge clk);
    load_we = 1'b0;
    #1 chk("coll_old_rdata", bus1.instr_rdata_o, 32'h0020_8113);
    @(negedge clk);
    bus1.instr_req_i = 1'b0;
    #1 chk("coll_new_rdata", bus1.instr_rdata_o, 32'hDEAD_BEEF);

    // LATENCY=3, MAX_OUTSTANDING=2 with req held: grant pattern 1,1,0,1,1,0.
    bus3.instr_addr_i = 32'h4;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus3.instr_req_i = (i < 6);
      #1;
      if (i < 6) chk("l3_gnt", 32'(bus3.instr_gnt_o), 32'(gnt_pat[i]));
      chk("l3_rvalid", 32'(bus3.instr_rvalid_o), 32'(rv_pat[i]));
      chk("l3_rdata",  bus3.instr_rdata_o, rv_pat[i] ? 32'h0010_0093 : 32'h0);
    end

    // Reset with responses in flight.
    @(negedge clk);
    bus3.instr_req_i  = 1'b1;
    bus3.instr_addr_i = 32'h0;
    #1 chk("rstf_gnt3a", 32'(bus3.instr_gnt_o), 32'h1);
    @(negedge clk);
    bus3.instr_addr_i = 32'h8;
    bus1.instr_req_i  = 1'b1;
    bus1.instr_addr_i = 32'hC;
    #1;
    chk("rstf_gnt3b", 32'(bus3.instr_gnt_o), 32'h1);
    chk("rstf_gnt1",  32'(bus1.instr_gnt_o), 32'h1);
    @(negedge clk);
    bus1.instr_req_i  = 1'b0;
    bus3.instr_addr_i = 32'h0;
    #1;
    chk("rstf_pre_rvalid1", 32'(bus1.instr_rvalid_o), 32'h1);
    chk("rstf_pre_rvalid3", 32'(bus3.instr_rvalid_o), 32'h0);
    rst = 1'b1;
    #1;
    chk("rstf_rvalid1", 32'(bus1.instr_rvalid_o), 32'h0);
    chk("rstf_rdata1",  bus1.instr_rdata_o,       32'h0);
    chk("rstf_gnt3",    32'(bus3.instr_gnt_o),    32'h0);
    @(negedge clk); #1;
    chk("rstf_hold_rvalid3", 32'(bus3.instr_rvalid_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus3.instr_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("rstf_flushed_rvalid3", 32'(bus3.instr_rvalid_o), 32'h0);
    end

    // Memory survives reset.
    @(negedge clk);
    bus3.instr_req_i  = 1'b1;
    bus3.instr_addr_i = 32'h4;
    bus1.instr_req_i  = 1'b1;
    bus1.instr_addr_i = 32'h8;
    #1 chk("post_gnt3", 32'(bus3.instr_gnt_o), 32'h1);
    @(negedge clk);
    bus3.instr_req_i = 1'b0;
    bus1.instr_req_i = 1'b0;
    #1;
    chk("post_rdata1",  bus1.instr_rdata_o,       32'hDEAD_BEEF);
    chk("post_rvalid3", 32'(bus3.instr_rvalid_o), 32'h0);
    @(negedge clk); #1;
    chk("post_rvalid3b", 32'(bus3.instr_rvalid_o), 32'h0);
    @(negedge clk); #1;
    chk("post_rvalid3c", 32'(bus3.instr_rvalid_o), 32'h1);
    chk("post_rdata3",   bus3.instr_rdata_o,       32'h0010_0093);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Memory-side responder for the instruction fetch bus: accepts fetch requests (req/gnt/addr), returns one 32-bit word per granted request on rdata with an rvalid pulse after a fixed latency, and flags out-of-range accesses on err. Sits between the fetch stage and the instruction RAM, and doubles as the bench/FPGA instruction memory model. Includes a side load port for program initialisation and a wait-state injection input for stressing the initiator's stall and FIFO logic.

## Interface
Parameters:
- DEPTH_WORDS, 1024: memory size in 32-bit words; power of two, at least 4.
- BASE_ADDR, 0: byte address of word 0; aligned to 4*DEPTH_WORDS.
- LATENCY, 1: cycles from the grant edge to rvalid; legal range 1..4.
- MAX_OUTSTANDING, 2: maximum number of granted requests that have not yet responded; legal range 1..4.

Ports:
- clk, input, 1: sole clock; all state changes on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- instr_req_i, input, 1: request valid.
- instr_gnt_o, output, 1: request accepted this cycle. Combinational.
- instr_addr_i, input, 32: byte address; bits [1:0] are ignored.
- instr_rdata_o, output, 32: response word. Registered.
- instr_rvalid_o, output, 1: response valid, one cycle per grant.
- instr_err_o, output, 1: response is an access fault. Qualified by rvalid.
- wait_i, input, 1: forces instr_gnt_o low (wait-state injection).
- load_we_i, input, 1: load-port write enable.
- load_addr_i, input, 32: load-port byte address; bits [1:0] are ignored.
- load_wdata_i, input, 32: load-port write data.

## Operation
- Grant: instr_gnt_o = instr_req_i & ~wait_i & ~rst & (inflight - instr_rvalid_o < MAX_OUTSTANDING).
  - inflight is the number of valid entries in the response delay line.
  - An entry retiring this cycle frees its slot for a same-cycle grant.
- Request decode on a grant:
  - in_range when BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS.
  - idx = (addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
  - Memory is read in the grant cycle. The entry {valid=1, err=~in_range, data = in_range ? mem[idx] : 0} enters stage 0 of a LATENCY-deep delay line.
- Delay line:
  - Shifts every cycle with no backpressure; the initiator must always accept rvalid.
  - The final stage drives instr_rvalid_o, instr_err_o and instr_rdata_o.
  - Responses are strictly in grant order.
- Outputs are forced to 0 whenever instr_rvalid_o is 0: rdata_o = 0, err_o = 0.
- Addresses:
  - Only word-aligned words are returned; the initiator does halfword alignment itself.
  - No address arithmetic wraps. An address past the top of memory, including 0xFFFFFFFC, gives an error, never an alias.
- Load port:
  - When load_we_i is high and load_addr_i is in range, mem[idx] is written at the clock edge.
  - An out-of-range load is silently dropped.
  - The load port operates independently of the fetch port.
  - If a grant and a load hit the same word in the same cycle, the response carries the old data.
- wait_i blocks only new grants; responses already in flight still complete on schedule.
- Reset:
  - All delay-line valid bits clear immediately and in-flight responses are discarded.
  - instr_rvalid_o, instr_err_o and instr_rdata_o go to 0; instr_gnt_o is 0 while rst is high.
  - Memory contents are not reset.

## Timing
- A grant at edge N produces instr_rvalid_o high during the cycle after edge N+LATENCY-1; with LATENCY=1, rvalid is high in the cycle right after the grant.
- Sustained throughput is one grant per cycle when MAX_OUTSTANDING >= LATENCY; otherwise MAX_OUTSTANDING grants per LATENCY cycles.
- instr_gnt_o has a combinational path from instr_req_i and wait_i. There is no combinational path from instr_addr_i to any output.
- rst assertion is asynchronous; deassertion is synchronised externally. The first grant is possible in the first cycle with rst low.

## Test plan
- Load mem[0..3] = 0x00000013, 0x00100093, 0x00208113, 0x00310193 with BASE_ADDR=0 and LATENCY=1. Hold req high with addresses 0, 4, 8, 12 on consecutive cycles -> four back-to-back grants, then rvalid in the four following cycles with the loaded words in order and err=0.
- LATENCY=3, MAX_OUTSTANDING=2, req held high -> gnt pattern 1,1,0,1,1,0…. inflight never exceeds 2, and each rvalid arrives exactly 3 cycles after its grant.
- Request addr 0x00001000 with DEPTH_WORDS=1024 -> granted. The response has rvalid=1, err=1, rdata=0. A following in-range request returns normally with err=0.
- wait_i high for 5 cycles with req high -> gnt=0 for those 5 cycles while the one previously granted response still completes. The grant resumes on the cycle wait_i falls.
- Grant at addr 8 in the same cycle as a load of 0xDEADBEEF to addr 8 -> the response returns the old word. The next read of addr 8 returns 0xDEADBEEF.
- Assert rst with two requests in flight -> rvalid drops to 0 immediately and neither response ever appears. After release, a read of a previously loaded address returns the loaded data.
